// File: rtl/uart_tx_pack.sv
// uart_tx_pack: UART transmitter on the musicbox return path toward the host.
//
// Takes a pair of 12-bit words per handshake, packs them into 24 bits and sends
// them as three 8N1 frames, most significant byte first:
//   byte0 = word_a[11:4]
//   byte1 = {word_a[3:0], word_b[11:8]}
//   byte2 = word_b[7:0]
// Data bits go out LSB first. Each bit holds exactly DIV = CLK_HZ / BAUD clocks.
// The next start bit follows a stop bit directly, with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to add an even parity bit
// (XOR of the 8 data bits) between the data bits and the stop bit of every byte.
// The default build (macro undefined) is pure 8N1 and has no parity state.
//
// Parameters:
//   CLK_HZ    system clock frequency in Hz
//   BAUD      line rate in bits per second (CLK_HZ / BAUD must be >= 2)
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous reset, active-high
//   in_valid  in   1   word pair on word_a / word_b is valid
//   in_ready  out  1   block can accept a pair (high only while idle)
//   word_a    in   12  first word, sent first
//   word_b    in   12  second word
//   UART_TX   out  1   serial line, idle high, registered
//   busy      out  1   high from the cycle after accept until done
//   done      out  1   one-cycle pulse when the last stop bit of byte2 ends

module uart_tx_pack #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] word_a,
    input  logic [11:0] word_b,
    output logic        UART_TX,
    output logic        busy,
    output logic        done
);

    // Bit period in clocks and the baud counter that measures it.
    localparam int unsigned Div     = CLK_HZ / BAUD;
    localparam int unsigned CntW    = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] DivLast = CntW'(Div - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;
`endif

    state_e          state_q;
    logic [CntW-1:0] baud_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [1:0]      byte_cnt_q;
    logic [23:0]     sr_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;

    logic [7:0]      cur_byte;
    logic [2:0]      next_bit_idx;
    logic            bit_end;

    // Byte currently on the line, picked MSB-first from the packed pair.
    always_comb begin
        cur_byte = sr_q[7:0];
        case (byte_cnt_q)
            2'd0:    cur_byte = sr_q[23:16];
            2'd1:    cur_byte = sr_q[15:8];
            default: cur_byte = sr_q[7:0];
        endcase
    end

    assign next_bit_idx = bit_cnt_q + 3'd1;

    // Last clock of the current bit period; every transition happens here so
    // the registered line value changes exactly on the bit boundary.
    assign bit_end = (baud_cnt_q == DivLast);

    assign in_ready = (state_q == StIdle);
    assign UART_TX  = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sr_q       <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    byte_cnt_q <= '0;
                    tx_q       <= 1'b1;
                    // in_ready is high throughout this state, so in_valid alone
                    // completes the handshake.
                    if (in_valid) begin
                        sr_q    <= {word_a, word_b};
                        state_q <= StStart;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        state_q    <= StData;
                        tx_q       <= cur_byte[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CntW'(1);
                    end
                end

                StData: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= StParity;
                            tx_q      <= ^cur_byte;
`else
                            state_q   <= StStop;
                            tx_q      <= 1'b1;
`endif
                        end else begin
                            bit_cnt_q <= next_bit_idx;
                            tx_q      <= cur_byte[next_bit_idx];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CntW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        state_q    <= StStop;
                        tx_q       <= 1'b1;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CntW'(1);
                    end
                end
`endif

                StStop: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (byte_cnt_q == 2'd2) begin
                            // Last stop bit ends: back to idle with a done pulse.
                            // in_ready rises in this same cycle, so a held
                            // in_valid starts the next pair one clock later.
                            byte_cnt_q <= '0;
                            state_q    <= StIdle;
                            tx_q       <= 1'b1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            // Next start bit follows the stop bit directly.
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            state_q    <= StStart;
                            tx_q       <= 1'b0;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CntW'(1);
                    end
                end

                default: begin
                    state_q    <= StIdle;
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    byte_cnt_q <= '0;
                    tx_q       <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule
